// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - UART transmitter with transmit FIFO; optional CTS flow control under UART_TX_CTS_EN
module uart_tx_fifo #(
  parameter int CLOCK_FREQ = 100_000_000,
  parameter int BAUD_RATE  = 115200,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          rst,
`ifdef UART_TX_CTS_EN
  input  logic                          cts_n,
`endif
  output logic                          tx,
  input  logic [DATA_BITS-1:0]          tx_data,
  input  logic                          tx_valid,
  output logic                          tx_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          busy
);

  localparam int CLKS_PER_BIT = CLOCK_FREQ / BAUD_RATE;
  localparam int CNT_W        = (CLKS_PER_BIT >= 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BIT_W        = (DATA_BITS >= 2) ? $clog2(DATA_BITS) : 1;
  localparam int PTR_W        = (FIFO_DEPTH >= 2) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW           = $clog2(FIFO_DEPTH) + 1;

  if (CLKS_PER_BIT < 2) begin : g_bad_cpb
    $error("uart_tx_fifo: CLOCK_FREQ / BAUD_RATE must be >= 2");
  end
  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
    $error("uart_tx_fifo: DATA_BITS must be 5..9");
  end
  if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
    $error("uart_tx_fifo: PARITY must be 0, 1 or 2");
  end
  if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop_bits
    $error("uart_tx_fifo: STOP_BITS must be 1 or 2");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("uart_tx_fifo: FIFO_DEPTH must be a power of two >= 2");
  end

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]     wr_ptr, rd_ptr;
  logic                 push, pop, can_pop, cts_ok;
  logic [DATA_BITS-1:0] head;
  logic                 head_par;

  state_t               state, state_nx;
  logic [CNT_W-1:0]     baud_cnt, baud_cnt_nx;
  logic [BIT_W-1:0]     bit_idx, bit_idx_nx;
  logic                 stop_idx, stop_idx_nx;
  logic [DATA_BITS-1:0] shreg, shreg_nx;
  logic                 par_bit, par_bit_nx;
  logic                 tx_nx;
  logic                 bit_end;

`ifdef UART_TX_CTS_EN
  logic [1:0] cts_sync;

  // two-flop synchronizer; resets to "not clear" so nothing leaves before a real sample
  always_ff @(posedge clk) begin
    if (rst) cts_sync <= 2'b11;
    else     cts_sync <= {cts_sync[0], cts_n};
  end

  assign cts_ok = ~cts_sync[1];
`else
  assign cts_ok = 1'b1;
`endif

  assign tx_ready = (fifo_count != CW'(FIFO_DEPTH));
  assign push     = tx_valid && tx_ready;
  assign head     = mem[rd_ptr];
  // odd parity inverts the XOR so that data plus parity holds an odd number of ones
  assign head_par = (PARITY == 1) ? ~(^head) : (^head);
  assign can_pop  = (fifo_count != '0) && cts_ok;
  assign bit_end  = (baud_cnt == CNT_W'(CLKS_PER_BIT - 1));
  assign busy     = (state != S_IDLE) || (fifo_count != '0);

  // FIFO storage write; contents need no reset since the pointers define validity
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= tx_data;
  end

  // FIFO pointers and occupancy; a simultaneous push and pop leaves the count unchanged
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + CW'(1);
        2'b01:   fifo_count <= fifo_count - CW'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // serializer next-state: tx is registered, so every bit change is scheduled on the edge that enters it
  always_comb begin
    state_nx    = state;
    baud_cnt_nx = baud_cnt + CNT_W'(1);
    bit_idx_nx  = bit_idx;
    stop_idx_nx = stop_idx;
    shreg_nx    = shreg;
    par_bit_nx  = par_bit;
    tx_nx       = tx;
    pop         = 1'b0;
    case (state)
      S_IDLE: begin
        baud_cnt_nx = '0;
        tx_nx       = 1'b1;
        if (can_pop) begin
          pop        = 1'b1;
          shreg_nx   = head;
          par_bit_nx = head_par;
          state_nx   = S_START;
          tx_nx      = 1'b0;
        end
      end
      S_START: begin
        if (bit_end) begin
          baud_cnt_nx = '0;
          bit_idx_nx  = '0;
          state_nx    = S_DATA;
          tx_nx       = shreg[0];
          shreg_nx    = shreg >> 1;
        end
      end
      S_DATA: begin
        if (bit_end) begin
          baud_cnt_nx = '0;
          if (bit_idx == BIT_W'(DATA_BITS - 1)) begin
            bit_idx_nx  = '0;
            stop_idx_nx = 1'b0;
            if (PARITY != 0) begin
              state_nx = S_PARITY;
              tx_nx    = par_bit;
            end else begin
              state_nx = S_STOP;
              tx_nx    = 1'b1;
            end
          end else begin
            bit_idx_nx = bit_idx + BIT_W'(1);
            tx_nx      = shreg[0];
            shreg_nx   = shreg >> 1;
          end
        end
      end
      S_PARITY: begin
        if (bit_end) begin
          baud_cnt_nx = '0;
          stop_idx_nx = 1'b0;
          state_nx    = S_STOP;
          tx_nx       = 1'b1;
        end
      end
      S_STOP: begin
        if (bit_end) begin
          baud_cnt_nx = '0;
          if (STOP_BITS == 1 || stop_idx) begin
            stop_idx_nx = 1'b0;
            // chaining straight into START keeps queued frames back to back
            if (can_pop) begin
              pop        = 1'b1;
              shreg_nx   = head;
              par_bit_nx = head_par;
              state_nx   = S_START;
              tx_nx      = 1'b0;
            end else begin
              state_nx = S_IDLE;
              tx_nx    = 1'b1;
            end
          end else begin
            stop_idx_nx = 1'b1;
          end
        end
      end
      default: begin
        state_nx    = S_IDLE;
        baud_cnt_nx = '0;
        tx_nx       = 1'b1;
      end
    endcase
  end

  // serializer state register; reset aborts any frame in flight and parks the line high
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      stop_idx <= 1'b0;
      shreg    <= '0;
      par_bit  <= 1'b0;
      tx       <= 1'b1;
    end else begin
      state    <= state_nx;
      baud_cnt <= baud_cnt_nx;
      bit_idx  <= bit_idx_nx;
      stop_idx <= stop_idx_nx;
      shreg    <= shreg_nx;
      par_bit  <= par_bit_nx;
      tx       <= tx_nx;
    end
  end

endmodule
